// File: rtl/beep_pattern_gen.sv
// Buzzer pattern player: each key_flag plays BEEP_NUM square-wave beeps separated by silences.
// Optional macro BEEP_RETRIG_EN lets a press during a pattern restart it from beep 0.
module beep_pattern_gen #(
   parameter int TONE_HALF = 4,
   parameter int ON_CYC    = 40,
   parameter int OFF_CYC   = 20,
   parameter int BEEP_NUM  = 2,
   parameter int CNT_W     = 16
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_flag,
   output logic beep,
   output logic busy,
   output logic done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYC - 1);
   localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYC - 1);
   localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_HALF - 1);
   localparam logic [7:0]       NUM_LAST  = 8'(BEEP_NUM - 1);

   state_t           state_q;
   logic [CNT_W-1:0] dur_q;
   logic [CNT_W-1:0] tone_q;
   logic [7:0]       num_q;
   logic             beep_q;
   logic             busy_q;
   logic             done_q;

   logic [CNT_W-1:0] dur_d;
   logic [CNT_W-1:0] tone_d;
   logic [7:0]       num_d;
   logic             retrig;

   assign dur_d  = dur_q + 1'b1;
   assign tone_d = tone_q + 1'b1;
   assign num_d  = num_q + 1'b1;

`ifdef BEEP_RETRIG_EN
   assign retrig = key_flag;
`else
   assign retrig = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         dur_q   <= '0;
         tone_q  <= '0;
         num_q   <= '0;
         beep_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               beep_q <= 1'b0;
               busy_q <= 1'b0;
               if (key_flag) begin
                  state_q <= ON;
                  dur_q   <= '0;
                  tone_q  <= '0;
                  num_q   <= '0;
                  beep_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ON: begin
               if (retrig) begin
                  dur_q  <= '0;
                  tone_q <= '0;
                  num_q  <= '0;
                  beep_q <= 1'b1;
               end else begin
                  dur_q <= dur_d;
                  if (tone_q == TONE_LAST) begin
                     tone_q <= '0;
                     beep_q <= ~beep_q;
                  end else begin
                     tone_q <= tone_d;
                  end
                  // Last ON cycle: these later assignments override the tone update above.
                  if (dur_q == ON_LAST) begin
                     dur_q  <= '0;
                     tone_q <= '0;
                     num_q  <= num_d;
                     beep_q <= 1'b0;
                     if (num_q < NUM_LAST) begin
                        state_q <= OFF;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end
               end
            end
            OFF: begin
               beep_q <= 1'b0;
               if (retrig) begin
                  state_q <= ON;
                  dur_q   <= '0;
                  tone_q  <= '0;
                  num_q   <= '0;
                  beep_q  <= 1'b1;
               end else if (dur_q == OFF_LAST) begin
                  state_q <= ON;
                  dur_q   <= '0;
                  tone_q  <= '0;
                  beep_q  <= 1'b1;
               end else begin
                  dur_q <= dur_d;
               end
            end
            default: begin
               state_q <= IDLE;
               beep_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign beep = beep_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Bench for beep_pattern_gen: timing-formula model per instance, per-cycle compare, literal pins.
// Two instances: default parameters and TONE_HALF=3/ON_CYC=10/BEEP_NUM=1.
module tb_beep_pattern_gen;

   logic clk = 1'b0;
   logic rst;
   logic key0, key1;
   logic beep0, busy0, done0;
   logic beep1, busy1, done1;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int st0 = -1;
   int st1 = -1;

`ifdef BEEP_RETRIG_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   always #5 clk = ~clk;

   beep_pattern_gen dut0 (
      .sys_clk (clk), .sys_rst (rst), .key_flag (key0),
      .beep    (beep0), .busy (busy0), .done (done0)
   );

   beep_pattern_gen #(
      .TONE_HALF (3), .ON_CYC (10), .OFF_CYC (20), .BEEP_NUM (1), .CNT_W (16)
   ) dut1 (
      .sys_clk (clk), .sys_rst (rst), .key_flag (key1),
      .beep    (beep1), .busy (busy1), .done (done1)
   );

   // Outputs in cycle c for a pattern whose first ON cycle is st.
   function automatic void model(input int st, input int c, input int th, input int on_c,
                                 input int off_c, input int bn,
                                 output logic b, output logic bz, output logic d);
      int rel, total, p;
      b = 1'b0; bz = 1'b0; d = 1'b0;
      if (st >= 0) begin
         rel   = c - st;
         total = bn * on_c + (bn - 1) * off_c;
         if (rel >= 0 && rel < total) begin
            bz = 1'b1;
            p  = rel % (on_c + off_c);
            if (p < on_c) b = ((p / th) % 2) == 0;
         end else if (rel == total) begin
            d = 1'b1;
         end
      end
   endfunction

   // Pattern starts are decided from the model's own busy in the cycle the key is sampled.
   always @(posedge clk) begin
      logic b, bz, d;
      if (rst) begin
         st0 = -1;
         st1 = -1;
      end else begin
         model(st0, cyc, 4, 40, 20, 2, b, bz, d);
         if (key0 && (!bz || RETRIG)) st0 = cyc + 1;
         model(st1, cyc, 3, 10, 20, 1, b, bz, d);
         if (key1 && (!bz || RETRIG)) st1 = cyc + 1;
      end
      cyc = cyc + 1;
   end

   task automatic cmp(input string name, input logic act, input logic exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic b, bz, d;
      if (cyc >= 1) begin
         model(st0, cyc, 4, 40, 20, 2, b, bz, d);
         cmp("dut0.beep", beep0, b);
         cmp("dut0.busy", busy0, bz);
         cmp("dut0.done", done0, d);
         model(st1, cyc, 3, 10, 20, 1, b, bz, d);
         cmp("dut1.beep", beep1, b);
         cmp("dut1.busy", busy1, bz);
         cmp("dut1.done", done1, d);
      end
   end

   task automatic at_cycle(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic lit(input int n, input string name, input logic act_sel, input logic exp);
      // act_sel is the output value as sampled by the caller at negedge
      cmp(name, act_sel, exp);
      $display("lit cycle=%0d %s=%b expect=%b", n, name, act_sel, exp);
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; key0 = 1'b0; key1 = 1'b0;
      at_cycle(1); key0 = 1'b1; key1 = 1'b1;
      at_cycle(2); key0 = 1'b0; key1 = 1'b0;
      neg(); lit(2, "rst.busy0", busy0, 1'b0); lit(2, "rst.beep0", beep0, 1'b0);
      lit(2, "rst.done0", done0, 1'b0);
      at_cycle(3); rst = 1'b0;
      at_cycle(4); neg(); lit(4, "post_rst.busy0", busy0, 1'b0);
      lit(4, "post_rst.busy1", busy1, 1'b0);

      // odd-parameter instance and default pattern interleaved in time order
      at_cycle(5); key1 = 1'b1;
      at_cycle(6); key1 = 1'b0;
      neg(); lit(6, "odd.beep_hi", beep1, 1'b1); lit(6, "odd.busy", busy1, 1'b1);
      at_cycle(8); neg(); lit(8, "odd.beep8", beep1, 1'b1);
      at_cycle(9); neg(); lit(9, "odd.beep9", beep1, 1'b0);
      at_cycle(10); key0 = 1'b1;
      neg(); lit(10, "odd.beep10", beep1, 1'b0);
      at_cycle(11); key0 = 1'b0;
      neg(); lit(11, "def.beep11", beep0, 1'b1); lit(11, "def.busy11", busy0, 1'b1);
      at_cycle(12); neg(); lit(12, "odd.beep12", beep1, 1'b1);
      at_cycle(15); neg(); lit(15, "odd.beep15", beep1, 1'b0);
      lit(15, "odd.busy15", busy1, 1'b1); lit(15, "def.beep15", beep0, 1'b0);
      at_cycle(16); key1 = 1'b1;
      neg(); lit(16, "odd.done16", done1, 1'b1); lit(16, "odd.busy16", busy1, 1'b0);
      lit(16, "odd.beep16", beep1, 1'b0);
      at_cycle(17); key1 = 1'b0;
      neg(); lit(17, "odd.retrig_beep", beep1, 1'b1); lit(17, "odd.done17", done1, 1'b0);
      at_cycle(19); neg(); lit(19, "def.beep19", beep0, 1'b1);
      at_cycle(27); neg(); lit(27, "odd.done27", done1, 1'b1);
      at_cycle(51); neg(); lit(51, "def.beep51", beep0, 1'b0); lit(51, "def.busy51", busy0, 1'b1);
      at_cycle(71); neg(); lit(71, "def.beep71", beep0, 1'b1);
      at_cycle(110); neg(); lit(110, "def.busy110", busy0, 1'b1);
      at_cycle(111); neg(); lit(111, "def.done111", done0, 1'b1);
      lit(111, "def.busy111", busy0, 1'b0); lit(111, "def.beep111", beep0, 1'b0);
      at_cycle(112); neg(); lit(112, "def.done112", done0, 1'b0);

      // press during ON
      at_cycle(200); key0 = 1'b1;
      at_cycle(201); key0 = 1'b0;
      at_cycle(220); key0 = 1'b1;
      at_cycle(221); key0 = 1'b0;
`ifdef BEEP_RETRIG_EN
      neg(); lit(221, "on_press.beep", beep0, 1'b1);
      at_cycle(301); neg(); lit(301, "on_press.done301", done0, 1'b0);
      at_cycle(321); neg(); lit(321, "on_press.done321", done0, 1'b1);
`else
      neg(); lit(221, "on_press.beep", beep0, 1'b0);
      at_cycle(301); neg(); lit(301, "on_press.done301", done0, 1'b1);
`endif

      // press during OFF
      at_cycle(400); key0 = 1'b1;
      at_cycle(401); key0 = 1'b0;
      at_cycle(450); key0 = 1'b1;
      at_cycle(451); key0 = 1'b0;
      neg(); lit(451, "off_press.busy", busy0, 1'b1);
`ifdef BEEP_RETRIG_EN
      lit(451, "off_press.beep", beep0, 1'b1);
      at_cycle(501); neg(); lit(501, "off_press.done501", done0, 1'b0);
      at_cycle(551); neg(); lit(551, "off_press.done551", done0, 1'b1);
`else
      lit(451, "off_press.beep", beep0, 1'b0);
      at_cycle(501); neg(); lit(501, "off_press.done501", done0, 1'b1);
`endif

      // mid-pattern reset then a fresh full pattern
      at_cycle(600); key0 = 1'b1;
      at_cycle(601); key0 = 1'b0;
      at_cycle(615); rst = 1'b1;
      at_cycle(616); rst = 1'b0;
      neg(); lit(616, "midrst.busy", busy0, 1'b0); lit(616, "midrst.beep", beep0, 1'b0);
      at_cycle(630); key0 = 1'b1;
      at_cycle(631); key0 = 1'b0;
      neg(); lit(631, "midrst.beep631", beep0, 1'b1);
      at_cycle(731); neg(); lit(731, "midrst.done731", done0, 1'b1);
      at_cycle(740);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/beep_pattern_gen.md
# beep_pattern_gen

Downstream consumer of the key debounce stage. Takes the one-cycle debounced press pulse and drives the passive buzzer with a square-wave tone played as a fixed pattern of BEEP_NUM beeps separated by silences. Reports activity and completion so the top level can gate further key handling.

## Interface
Parameters:
- TONE_HALF, 4: tone half-period in sys_clk cycles (≥1).
- ON_CYC, 40: length of each beep in cycles (≥1).
- OFF_CYC, 20: silence between consecutive beeps in cycles (≥1).
- BEEP_NUM, 2: beeps per pattern (1..255).
- CNT_W, 16: width of the duration and tone counters. ON_CYC, OFF_CYC and TONE_HALF must each be < 2^CNT_W.

Ports:
- sys_clk, in, 1: single clock; all logic is on its rising edge.
- sys_rst, in, 1: synchronous, active-high reset.
- key_flag, in, 1: one-cycle debounced press pulse from the debounce stage.
- beep, out, 1: buzzer drive; toggles as a square wave during ON, 0 otherwise.
- busy, out, 1: high while a pattern is in progress.
- done, out, 1: one-cycle pulse when a pattern completes.

## Operation
- FSM states: IDLE, ON, OFF. Counters:
  - dur_cnt (CNT_W): cycles spent in the current state.
  - tone_cnt (CNT_W): position within the current tone half-period.
  - num_cnt (8 bits): beeps already completed.
- IDLE:
  - beep=0, busy=0.
  - On key_flag=1: go to ON and clear dur_cnt, tone_cnt and num_cnt.
- ON:
  - beep is high for TONE_HALF cycles, then low for TONE_HALF, and repeats.
  - The tone phase restarts high at the start of every beep.
  - After ON_CYC cycles, num_cnt increments.
  - If num_cnt+1 < BEEP_NUM: go to OFF. Otherwise: go to IDLE and pulse done.
- OFF:
  - beep=0.
  - After OFF_CYC cycles: go to ON with the tone phase reset.
- key_flag while busy is ignored (default build; see Configuration).
- All outputs are registered.
- Reset:
  - sys_rst=1 forces the FSM to IDLE, clears all counters, and drives beep=0, busy=0, done=0 at the next edge.
  - This applies at any point, including mid-pattern.
  - Reset has priority over a simultaneous key_flag.
- ON_CYC need not be a multiple of 2·TONE_HALF. The last tone half-period is truncated when ON ends.

## Timing
- key_flag is high on the edge that ends cycle t, with the FSM in IDLE.
  - From cycle t+1: busy=1, beep=1.
  - beep first falls at t+1+TONE_HALF.
- Beep k (0-based) occupies cycles t+1+k·(ON_CYC+OFF_CYC) through t+k·(ON_CYC+OFF_CYC)+ON_CYC.
- Pattern end:
  - busy falls and done=1 for exactly one cycle at t+1+BEEP_NUM·ON_CYC+(BEEP_NUM−1)·OFF_CYC.
  - beep=0 in that same cycle.
- Defaults: busy spans 100 cycles (t+1..t+100). done occurs at cycle t+101.
- A key_flag arriving in the same cycle that done is high is accepted: the FSM is already IDLE in that cycle. beep rises again the next cycle.
- Minimum retrigger spacing is therefore pattern length + 1 cycle.
- No output glitches. beep changes only on sys_clk edges.

## Configuration
- Macro: BEEP_RETRIG_EN.
- Defined:
  - key_flag in ON or OFF restarts the pattern.
  - The FSM goes to ON with num_cnt, dur_cnt and tone_cnt cleared. beep=1 on the next cycle.
  - done is not pulsed for the aborted pattern. busy stays high continuously.
- Undefined: key_flag is ignored whenever busy=1.

## Test plan
- Reset behaviour: hold sys_rst=1 for 3 cycles, with key_flag pulsing during reset.
  - Required: beep=0, busy=0, done=0 throughout.
  - Required: no pattern starts after reset is released.
- Default pattern: single key_flag pulse at cycle 10.
  - beep toggles every 4 cycles during cycles 11–50 and 71–110, and is 0 during 51–70.
  - busy is high during 11–110.
  - done is high only in cycle 111.
- Ignored press (macro undefined): second key_flag at cycle 30 of that pattern.
  - Waveform is identical to the default-pattern case.
  - Exactly one done pulse.
- Retrigger (BEEP_RETRIG_EN defined): second key_flag at cycle 60 (inside OFF).
  - beep restarts high at cycle 61.
  - busy stays high continuously.
  - Single done at cycle 61+100=161.
- Mid-pattern reset: sys_rst=1 at cycle 25.
  - beep=0 and busy=0 from cycle 26.
  - No done pulse.
  - A key_flag after reset release plays a full pattern from beep 0.
- Odd parameters: TONE_HALF=3, ON_CYC=10, BEEP_NUM=1, key_flag at cycle 5.
  - beep is high during 6–8 and 12–14, and low during 9–11 and 15.
  - done is high at cycle 16.
  - No OFF state is entered.
